// File: rtl/sfp_div_pkg.sv
// Shared types and elaboration-time helpers for the signed fixed-point vector divider.
package sfp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // One quotient bit per iteration; the dividend is pre-scaled by 2^QW.
  function automatic int calc_k(input int iw, input int qw);
    return iw + qw + qw;
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sfp_if.sv
// N-lane bundle of W-bit signed fixed-point values.
interface sfp_if #(
  parameter int N = 3,
  parameter int W = 16
);
  logic [N-1:0][W-1:0] v;

  modport in  (input  v);
  modport out (output v);
endinterface

// File: rtl/sfp_div_lane.sv
// One lane of the restoring divider: sign/magnitude prep, bit-serial iteration,
// zero-divisor handling and the final sign/saturate/wrap stage.
module sfp_div_lane
  import sfp_div_pkg::*;
#(
  parameter int IW   = 8,
  parameter int QW   = 8,
  parameter int CLIP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic [IW+QW-1:0]   a_i,
  input  logic [IW+QW-1:0]   b_i,
  output logic [IW+QW-1:0]   res_o,
  output logic               dbz_o,
  output logic               clip_o
);

  localparam int W  = IW + QW;
  localparam int DW = W + QW;
  localparam logic [63:0]   MAX64   = sat_max(W);
  localparam logic [63:0]   MIN64   = sat_min(W);
  localparam logic [W-1:0]  MAX_V   = MAX64[W-1:0];
  localparam logic [W-1:0]  MIN_V   = MIN64[W-1:0];
  localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] LIM_POS = {{QW{1'b0}}, MAX_V};
  localparam logic [DW-1:0] LIM_NEG = {{QW{1'b0}}, MIN_V};

  // Magnitudes are held as W-bit unsigned: |-2^(W-1)| = 2^(W-1) still fits.
  logic [W-1:0]  mag_a_s, mag_b_s;
  logic [W:0]    r_sh_s;
  logic          ge_s;
  logic [DW-1:0] dvd_d, dvd_q;
  logic [W-1:0]  rem_d, rem_q;
  logic [W-1:0]  mag_b_d, mag_b_q;
  logic          neg_d, neg_q;
  logic          dbz_d, dbz_q;
  logic          a_neg_d, a_neg_q;
  logic          a_zero_d, a_zero_q;
  logic          ovf_s;
  logic [W-1:0]  wrap_s;

  // Operand latch on start, one restoring step per step pulse; dvd doubles as quotient.
  always_comb begin
    mag_a_s  = a_i[W-1] ? (~a_i + ONE_W) : a_i;
    mag_b_s  = b_i[W-1] ? (~b_i + ONE_W) : b_i;
    r_sh_s   = {rem_q, dvd_q[DW-1]};
    ge_s     = (r_sh_s >= {1'b0, mag_b_q});
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    mag_b_d  = mag_b_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
    a_neg_d  = a_neg_q;
    a_zero_d = a_zero_q;
    if (start) begin
      dvd_d    = {mag_a_s, {QW{1'b0}}};
      rem_d    = '0;
      mag_b_d  = mag_b_s;
      neg_d    = a_i[W-1] ^ b_i[W-1];
      dbz_d    = (b_i == '0);
      a_neg_d  = a_i[W-1];
      a_zero_d = (a_i == '0);
    end else if (step && !dbz_q) begin
      rem_d = ge_s ? (r_sh_s[W-1:0] - mag_b_q) : r_sh_s[W-1:0];
      dvd_d = {dvd_q[DW-2:0], ge_s};
    end else begin
      dvd_d = dvd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q    <= '0;
      rem_q    <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      a_zero_q <= 1'b0;
    end else begin
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      mag_b_q  <= mag_b_d;
      neg_q    <= neg_d;
      dbz_q    <= dbz_d;
      a_neg_q  <= a_neg_d;
      a_zero_q <= a_zero_d;
    end
  end

  // Sign application with range check; negative results may reach 2^(W-1) in magnitude.
  always_comb begin
    ovf_s  = neg_q ? (dvd_q > LIM_NEG) : (dvd_q > LIM_POS);
    wrap_s = neg_q ? (~dvd_q[W-1:0] + ONE_W) : dvd_q[W-1:0];
    res_o  = '0;
    clip_o = 1'b0;
    dbz_o  = dbz_q;
    if (dbz_q) begin
      if (a_zero_q) begin
        res_o = '0;
      end else begin
        res_o = a_neg_q ? MIN_V : MAX_V;
      end
    end else if (ovf_s) begin
      clip_o = 1'b1;
      if (CLIP != 0) begin
        res_o = neg_q ? MIN_V : MAX_V;
      end else begin
        res_o = wrap_s;
      end
    end else begin
      res_o = wrap_s;
    end
  end

endmodule

// File: rtl/sfp_vec_div.sv
// N-lane signed fixed-point divider: lock-step restoring lanes under a
// three-state accept/iterate/present controller with valid/ready handshakes.
module sfp_vec_div
  import sfp_div_pkg::*;
#(
  parameter int N    = 3,
  parameter int IW   = 8,
  parameter int QW   = 8,
  parameter int CLIP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  sfp_if.in            a,
  sfp_if.in            b,
  output logic         out_valid,
  input  logic         out_ready,
  sfp_if.out           out,
  output logic [N-1:0] div_by_zero,
  output logic [N-1:0] clipping
);

  localparam int W  = IW + QW;
  localparam int K  = calc_k(IW, QW);
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] K_C   = CW'(K);
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  state_e              state_d, state_q;
  logic [CW-1:0]       cnt_d, cnt_q;
  logic                in_ready_d, in_ready_q;
  logic                out_valid_d, out_valid_q;
  logic [N-1:0][W-1:0] res_d, res_q;
  logic [N-1:0]        dbz_d, dbz_q;
  logic [N-1:0]        clip_d, clip_q;
  logic                start_s, step_s, load_s;
  logic [N-1:0][W-1:0] lane_res_s;
  logic [N-1:0]        lane_dbz_s, lane_clip_s;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sfp_div_lane #(
      .IW   (IW),
      .QW   (QW),
      .CLIP (CLIP)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_s),
      .step   (step_s),
      .a_i    (a.v[i]),
      .b_i    (b.v[i]),
      .res_o  (lane_res_s[i]),
      .dbz_o  (lane_dbz_s[i]),
      .clip_o (lane_clip_s[i])
    );
  end

  // Controller: K step cycles after accept, then one cycle to capture lane results.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_s = 1'b0;
    step_s  = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          start_s = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == K_C) begin
          state_d = DONE;
          load_s  = 1'b1;
        end else begin
          step_s = 1'b1;
          cnt_d  = cnt_q + ONE_C;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    res_d       = load_s ? lane_res_s  : res_q;
    dbz_d       = load_s ? lane_dbz_s  : dbz_q;
    clip_d      = load_s ? lane_clip_s : clip_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      dbz_q       <= '0;
      clip_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      dbz_q       <= dbz_d;
      clip_q      <= clip_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out.v       = res_q;
  assign div_by_zero = dbz_q;
  assign clipping    = clip_q;

endmodule

// File: tb/tb_sfp_vec_div.sv
// Directed and randomized checks of sfp_vec_div (saturating and wrapping builds)
// against an integer-arithmetic reference.
module tb_sfp_vec_div;

  localparam int N   = 3;
  localparam int IW  = 8;
  localparam int QW  = 8;
  localparam int W   = 16;
  localparam int LAT = 25;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready0, out_valid0, in_ready1, out_valid1;
  logic [N-1:0] dbz0, clip0, dbz1, clip1;
  int           checks = 0;
  int           errors = 0;

  sfp_if #(.N(N), .W(W)) a_if ();
  sfp_if #(.N(N), .W(W)) b_if ();
  sfp_if #(.N(N), .W(W)) o0_if ();
  sfp_if #(.N(N), .W(W)) o1_if ();

  always #5 clk = ~clk;

  sfp_vec_div #(.N(N), .IW(IW), .QW(QW), .CLIP(1)) u_dut_sat (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready0),
    .a (a_if), .b (b_if), .out_valid (out_valid0), .out_ready (out_ready),
    .out (o0_if), .div_by_zero (dbz0), .clipping (clip0)
  );

  sfp_vec_div #(.N(N), .IW(IW), .QW(QW), .CLIP(0)) u_dut_wrap (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready1),
    .a (a_if), .b (b_if), .out_valid (out_valid1), .out_ready (out_ready),
    .out (o1_if), .div_by_zero (dbz1), .clipping (clip1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued a/b in Q8.8 is (a*256)/b with truncation toward zero.
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input bit sat,
                                  output logic [15:0] r, output logic d, output logic c);
    longint ai, bi, q;
    ai = longint'($signed(a));
    bi = longint'($signed(b));
    d = 1'b0;
    c = 1'b0;
    if (bi == 0) begin
      d = 1'b1;
      r = (ai > 0) ? 16'h7FFF : ((ai < 0) ? 16'h8000 : 16'h0000);
    end else begin
      q = (ai * 256) / bi;
      if (q > 32767 || q < -32768) begin
        c = 1'b1;
        if (sat) r = (q > 0) ? 16'h7FFF : 16'h8000;
        else     r = q[15:0];
      end else begin
        r = q[15:0];
      end
    end
  endfunction

  task automatic run_op(input string tag, input logic [N-1:0][15:0] av,
                        input logic [N-1:0][15:0] bv, input int hold);
    int n;
    logic [15:0] r;
    logic d, c;
    logic [N-1:0][15:0] snap;
    a_if.v = av;
    b_if.v = bv;
    n = 0;
    while (!in_ready0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy_before"}, 32'(in_ready0), 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a_if.v = {N{16'hDEAD}};
    b_if.v = {N{16'h0000}};
    check({tag, "_rdy_busy"}, 32'(in_ready0), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid0 && n < 60);
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    check({tag, "_valid_wrap"}, 32'(out_valid1), 32'd1);
    for (int i = 0; i < N; i++) begin
      ref_div(av[i], bv[i], 1'b1, r, d, c);
      check($sformatf("%s_l%0d_sat_res", tag, i), 32'(o0_if.v[i]), 32'(r));
      check($sformatf("%s_l%0d_sat_dbz", tag, i), 32'(dbz0[i]), 32'(d));
      check($sformatf("%s_l%0d_sat_clip", tag, i), 32'(clip0[i]), 32'(c));
      ref_div(av[i], bv[i], 1'b0, r, d, c);
      check($sformatf("%s_l%0d_wrap_res", tag, i), 32'(o1_if.v[i]), 32'(r));
      check($sformatf("%s_l%0d_wrap_dbz", tag, i), 32'(dbz1[i]), 32'(d));
      check($sformatf("%s_l%0d_wrap_clip", tag, i), 32'(clip1[i]), 32'(c));
    end
    if (hold > 0) begin
      snap = o0_if.v;
      a_if.v = av;
      b_if.v = bv;
      in_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check($sformatf("%s_hold%0d_out", tag, h), 32'(o0_if.v == snap), 32'd1);
        check($sformatf("%s_hold%0d_vld", tag, h), 32'(out_valid0), 32'd1);
        check($sformatf("%s_hold%0d_rdy", tag, h), 32'(in_ready0), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, "_vld_drop"}, 32'(out_valid0), 32'd0);
    check({tag, "_rdy_rise"}, 32'(in_ready0), 32'd1);
  endtask

  initial begin
    logic [N-1:0][15:0] av, bv;
    logic stray;
    int n;
    a_if.v = '0;
    b_if.v = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_out", 32'(o0_if.v), 32'd0);
    check("rst_dbz", 32'(dbz0), 32'd0);
    check("rst_clip", 32'(clip0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic", {16'h0A00, 16'h0100, 16'h0300}, {16'h0500, 16'h0200, 16'h0180}, 0);
    run_op("signs", {16'hFE00, 16'h0100, 16'hFF00}, {16'hFF00, 16'hFC00, 16'h0400}, 0);
    run_op("dbz",   {16'h0000, 16'hFF00, 16'h0100}, {16'h0000, 16'h0000, 16'h0000}, 0);
    run_op("ovf",   {16'h0100, 16'h0100, 16'h6400}, {16'h0100, 16'h0100, 16'h0001}, 0);
    run_op("minneg", {16'h8000, 16'h8000, 16'h8000}, {16'hFFFF, 16'h0100, 16'hFF00}, 0);
    run_op("bp",    {16'h0300, 16'hF000, 16'h7FFF}, {16'h0180, 16'h0300, 16'h8000}, 10);

    // Reset during iteration 5 must abandon the operation.
    a_if.v = {16'h0100, 16'h0100, 16'h0300};
    b_if.v = {16'h0100, 16'h0100, 16'h0180};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid0), 32'd0);
    check("midrst_in_ready", 32'(in_ready0), 32'd1);
    check("midrst_out", 32'(o0_if.v), 32'd0);
    stray = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (out_valid0) stray = 1'b1;
    end
    check("midrst_no_valid", 32'(stray), 32'd0);
    run_op("after_rst", {16'h0300, 16'h0300, 16'h0300}, {16'h0180, 16'h0180, 16'h0180}, 0);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) begin
        av[i] = 16'($urandom_range(0, 65535));
        case ($urandom_range(0, 7))
          0: bv[i] = 16'h0000;
          1: bv[i] = 16'($urandom_range(1, 8));
          2: bv[i] = 16'(-$urandom_range(1, 8));
          default: bv[i] = 16'($urandom_range(0, 65535));
        endcase
      end
      run_op($sformatf("rnd%0d", t), av, bv, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
